// File: rtl/ca90_im_pkg.sv
// Shared types for the CA90 item-memory generator.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ca90_im_pkg;

  // Generator control states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/ca90_unit.sv
// One CA90 step: data_o = rotl(data_i, s) ^ rotr(data_i, s).
// Latency: combinational.
// Backpressure: none; a pure function of its inputs.
//
// Ports:
//   data_i      in  Dimension   vector to transform
//   shift_amt_i in  ShiftWidth  rotate amount s
//   data_o      out Dimension   transformed vector
module ca90_unit #(
  parameter int unsigned Dimension  = 512,
  parameter int unsigned ShiftWidth = 7
) (
  input  logic [Dimension-1:0]  data_i,
  input  logic [ShiftWidth-1:0] shift_amt_i,
  output logic [Dimension-1:0]  data_o
);

  logic [31:0]          s_fwd;
  logic [31:0]          s_rev;
  logic [Dimension-1:0] rot_l;
  logic [Dimension-1:0] rot_r;

  // A shift of 0 gives rot_l == rot_r == data_i, so the XOR is all-zero.
  // The complementary shift (Dimension - s) moves every bit out when s is 0.
  always_comb begin
    s_fwd  = 32'(shift_amt_i);
    s_rev  = Dimension - s_fwd;
    rot_l  = (data_i << s_fwd) | (data_i >> s_rev);
    rot_r  = (data_i >> s_fwd) | (data_i << s_rev);
    data_o = rot_l ^ rot_r;
  end

endmodule

// File: rtl/ca90_im_gen.sv
// Item-vector generator: im_o = CA90^a(seed), one CA90 step per clock.
// Latency: a+1 clocks from request handshake to im_valid_o (cache hit: (a-L)+1).
// Backpressure: single request in flight; result held in DONE until im_ready_i.
//
// Optional feature macro: CA90_IM_CACHE_EN keeps the last delivered index and
// vector so a later request with a larger index and same shift resumes from it.
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   seed_i / seed_wr_i                 seed vector and its load strobe (IDLE only)
//   shift_amt_i                        CA90 rotate amount, latched with the request
//   im_addr_i / _valid_i / _ready_o    request channel (item index a)
//   im_o / im_valid_o / im_ready_i     result channel
//   busy_o                             high whenever the FSM is not in IDLE
// NumTotIm must be a power of two.
module ca90_im_gen
  import ca90_im_pkg::*;
#(
  parameter  int unsigned Dimension   = 512,
  parameter  int unsigned MaxShiftAmt = 128,
  parameter  int unsigned NumTotIm    = 1024,
  localparam int unsigned ShiftWidth  = $clog2(MaxShiftAmt),
  localparam int unsigned AddrWidth   = $clog2(NumTotIm)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [Dimension-1:0]  seed_i,
  input  logic                  seed_wr_i,
  input  logic [ShiftWidth-1:0] shift_amt_i,
  input  logic [AddrWidth-1:0]  im_addr_i,
  input  logic                  im_addr_valid_i,
  output logic                  im_addr_ready_o,
  output logic [Dimension-1:0]  im_o,
  output logic                  im_valid_o,
  input  logic                  im_ready_i,
  output logic                  busy_o
);

  state_e                state_q, state_d;
  logic [Dimension-1:0]  seed_q, seed_d;
  logic [Dimension-1:0]  work_q, work_d;
  logic [AddrWidth-1:0]  cnt_q, cnt_d;
  logic [ShiftWidth-1:0] shift_q, shift_d;
  logic [Dimension-1:0]  step_vec;
  logic [Dimension-1:0]  start_vec;
  logic [AddrWidth-1:0]  start_cnt;
  logic                  req_hs;
  logic                  res_hs;
  logic                  seed_ld;

  // Ready is masked by reset so nothing is accepted until reset is released.
  assign im_addr_ready_o = (state_q == IDLE) && rst_ni;
  assign im_valid_o      = (state_q == DONE);
  assign busy_o          = (state_q != IDLE);
  assign im_o            = work_q;

  assign req_hs  = im_addr_valid_i && im_addr_ready_o;
  assign res_hs  = (state_q == DONE) && im_ready_i;
  // A request in the same cycle wins over a seed write.
  assign seed_ld = (state_q == IDLE) && seed_wr_i && !req_hs;

  // The step always uses the latched shift so later shift_amt_i changes
  // cannot disturb an in-flight computation.
  ca90_unit #(
    .Dimension  (Dimension),
    .ShiftWidth (ShiftWidth)
  ) u_ca90_unit (
    .data_i      (work_q),
    .shift_amt_i (shift_q),
    .data_o      (step_vec)
  );

`ifdef CA90_IM_CACHE_EN
  logic                  cache_vld_q;
  logic [AddrWidth-1:0]  cache_idx_q;
  logic [Dimension-1:0]  cache_vec_q;
  logic [ShiftWidth-1:0] cache_shift_q;
  logic [AddrWidth-1:0]  req_idx_q;
  logic                  cache_hit;

  always_comb begin
    cache_hit = cache_vld_q && (im_addr_i >= cache_idx_q) && (shift_amt_i == cache_shift_q);
    start_vec = cache_hit ? cache_vec_q : seed_q;
    start_cnt = cache_hit ? (im_addr_i - cache_idx_q) : im_addr_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cache_vld_q   <= 1'b0;
      cache_idx_q   <= '0;
      cache_vec_q   <= '0;
      cache_shift_q <= '0;
      req_idx_q     <= '0;
    end else begin
      if (req_hs) begin
        req_idx_q <= im_addr_i;
      end
      if (seed_ld) begin
        cache_vld_q <= 1'b0;
      end else if (res_hs) begin
        cache_vld_q   <= 1'b1;
        cache_idx_q   <= req_idx_q;
        cache_vec_q   <= work_q;
        cache_shift_q <= shift_q;
      end
    end
  end
`else
  assign start_vec = seed_q;
  assign start_cnt = im_addr_i;
`endif

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (req_hs) begin
          shift_d = shift_amt_i;
          work_d  = start_vec;
          cnt_d   = start_cnt;
          state_d = (start_cnt == '0) ? DONE : COMPUTE;
        end else if (seed_ld) begin
          seed_d = seed_i;
        end
      end
      COMPUTE: begin
        work_d = step_vec;
        cnt_d  = cnt_q - AddrWidth'(1);
        if (cnt_q == AddrWidth'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (im_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      seed_q  <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: tb/tb_ca90_im_gen.sv
// Self-checking bench for ca90_im_gen (Dimension=8, MaxShiftAmt=4, NumTotIm=16).
// Latency: n/a.
// Backpressure: n/a.
module tb_ca90_im_gen;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] seed_i = '0;
  logic       seed_wr_i = 1'b0;
  logic [1:0] shift_amt_i = '0;
  logic [3:0] im_addr_i = '0;
  logic       im_addr_valid_i = 1'b0;
  logic       im_addr_ready_o;
  logic [7:0] im_o;
  logic       im_valid_o;
  logic       im_ready_i = 1'b0;
  logic       busy_o;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  ca90_im_gen #(
    .Dimension   (8),
    .MaxShiftAmt (4),
    .NumTotIm    (16)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .seed_i          (seed_i),
    .seed_wr_i       (seed_wr_i),
    .shift_amt_i     (shift_amt_i),
    .im_addr_i       (im_addr_i),
    .im_addr_valid_i (im_addr_valid_i),
    .im_addr_ready_o (im_addr_ready_o),
    .im_o            (im_o),
    .im_valid_o      (im_valid_o),
    .im_ready_i      (im_ready_i),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference CA90 straight from the definition: bit i of rotl(v,s) is
  // v[i-s], bit i of rotr(v,s) is v[i+s], indices modulo 8.
  function automatic logic [7:0] ca90_ref(input logic [7:0] v, input int s);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[(i - s + 8) % 8] ^ v[(i + s) % 8];
    end
    return r;
  endfunction

  function automatic logic [7:0] ca90_pow(input logic [7:0] v, input int s, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = ca90_ref(r, s);
    return r;
  endfunction

  // Transaction-level model: one pending request with an expected vector and
  // the cycle number at which its result must appear.
  int         cyc = 0;
  bit         m_pend = 1'b0;
  int         m_due = 0;
  int         m_n;
  logic [7:0] m_exp = '0;
  logic [7:0] m_seed = '0;
  logic [7:0] m_st;
`ifdef CA90_IM_CACHE_EN
  bit         m_cvld = 1'b0;
  logic [3:0] m_idx, m_cidx;
  logic [1:0] m_sh, m_csh;
  logic [7:0] m_cvec;
`endif

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_pend = 1'b0;
      m_seed = '0;
`ifdef CA90_IM_CACHE_EN
      m_cvld = 1'b0;
`endif
    end else begin
      if (!m_pend) begin
        if (im_addr_valid_i) begin
          m_st = m_seed;
          m_n  = int'(im_addr_i);
`ifdef CA90_IM_CACHE_EN
          if (m_cvld && im_addr_i >= m_cidx && shift_amt_i == m_csh) begin
            m_st = m_cvec;
            m_n  = int'(im_addr_i) - int'(m_cidx);
          end
          m_idx = im_addr_i;
          m_sh  = shift_amt_i;
`endif
          m_exp  = ca90_pow(m_st, int'(shift_amt_i), m_n);
          m_due  = cyc + 1 + m_n;
          m_pend = 1'b1;
        end else if (seed_wr_i) begin
          m_seed = seed_i;
`ifdef CA90_IM_CACHE_EN
          m_cvld = 1'b0;
`endif
        end
      end else if (cyc >= m_due && im_ready_i) begin
        m_pend = 1'b0;
`ifdef CA90_IM_CACHE_EN
        m_cvld = 1'b1;
        m_cidx = m_idx;
        m_cvec = m_exp;
        m_csh  = m_sh;
`endif
      end
      cyc++;
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      if (!rst_ni) begin
        chk("rst_ready", 32'(im_addr_ready_o), 32'd0);
        chk("rst_valid", 32'(im_valid_o), 32'd0);
        chk("rst_busy",  32'(busy_o), 32'd0);
        chk("rst_im",    32'(im_o), 32'd0);
      end else begin
        chk("ready", 32'(im_addr_ready_o), 32'(!m_pend));
        chk("busy",  32'(busy_o), 32'(m_pend));
        chk("valid", 32'(im_valid_o), 32'(m_pend && cyc >= m_due));
        if (m_pend && cyc >= m_due) chk("im_o", 32'(im_o), 32'(m_exp));
      end
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_seed(input logic [7:0] v);
    seed_i    = v;
    seed_wr_i = 1'b1;
    tick();
    seed_wr_i = 1'b0;
  endtask

  // Issue one request, measure clocks from the handshake to im_valid_o,
  // hold the result for 'hold' cycles, then consume it.
  task automatic do_req(input logic [3:0] a, input logic [1:0] s, input int hold,
                        input bit pulse_seed, input bit coincide,
                        output logic [7:0] vec, output int lat);
    int n;
    im_addr_i       = a;
    shift_amt_i     = s;
    im_addr_valid_i = 1'b1;
    if (coincide) begin
      seed_i    = 8'(~a);
      seed_wr_i = 1'b1;
    end
    n = 0;
    while (!im_addr_ready_o && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("req_ready_timeout", 32'(n), 32'd0);
    tick();
    im_addr_valid_i = 1'b0;
    seed_wr_i       = 1'b0;
    shift_amt_i     = 2'($urandom_range(0, 3));
    lat = 1;
    while (!im_valid_o && lat < 40) begin
      tick();
      lat++;
    end
    if (lat >= 40) chk("valid_timeout", 32'(lat), 32'd0);
    vec = im_o;
    for (int i = 0; i < hold; i++) begin
      if (pulse_seed && i == 2) begin
        seed_i    = 8'hFF;
        seed_wr_i = 1'b1;
      end else begin
        seed_wr_i = 1'b0;
      end
      tick();
    end
    seed_wr_i  = 1'b0;
    im_ready_i = 1'b1;
    tick();
    im_ready_i = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    int         l;
    int         seen;
    int         r;

    rst_ni = 1'b0;
    tick();
    chk_en = 1'b1;
    repeat (2) tick();
    rst_ni = 1'b1;
    #1;
    chk("post_rst_ready", 32'(im_addr_ready_o), 32'd1);
    chk("post_rst_busy",  32'(busy_o), 32'd0);
    chk("post_rst_valid", 32'(im_valid_o), 32'd0);
    chk("post_rst_im",    32'(im_o), 32'd0);
    tick();

    write_seed(8'h01);
    do_req(4'd1, 2'd1, 0, 1'b0, 1'b0, v, l);
    chk("a1_im", 32'(v), 32'h82);
    chk("a1_lat", 32'(l), 32'd2);
    do_req(4'd2, 2'd1, 0, 1'b0, 1'b0, v, l);
    chk("a2_im", 32'(v), 32'h44);
`ifdef CA90_IM_CACHE_EN
    chk("a2_lat", 32'(l), 32'd2);
`else
    chk("a2_lat", 32'(l), 32'd3);
`endif
    do_req(4'd0, 2'd1, 0, 1'b0, 1'b0, v, l);
    chk("a0_im", 32'(v), 32'h01);
    chk("a0_lat", 32'(l), 32'd1);

    // Result held for 5 cycles with a seed write attempted meanwhile.
    do_req(4'd1, 2'd1, 5, 1'b1, 1'b0, v, l);
    chk("hold_im", 32'(v), 32'h82);
    do_req(4'd0, 2'd1, 0, 1'b0, 1'b0, v, l);
    chk("hold_seed_kept", 32'(v), 32'h01);

    // Shift 0 collapses to zero after any iteration.
    write_seed(8'h5A);
    do_req(4'd3, 2'd0, 0, 1'b0, 1'b0, v, l);
    chk("shift0_im", 32'(v), 32'h00);
    do_req(4'd0, 2'd0, 0, 1'b0, 1'b0, v, l);
    chk("shift0_a0_im", 32'(v), 32'h5A);

    // Cache sequence (plain recompute latencies when the cache is absent).
    write_seed(8'h01);
    do_req(4'd2, 2'd1, 0, 1'b0, 1'b0, v, l);
    chk("c_a2_lat", 32'(l), 32'd3);
    do_req(4'd5, 2'd1, 0, 1'b0, 1'b0, v, l);
`ifdef CA90_IM_CACHE_EN
    chk("c_a5_lat", 32'(l), 32'd4);
`else
    chk("c_a5_lat", 32'(l), 32'd6);
`endif
    do_req(4'd3, 2'd1, 0, 1'b0, 1'b0, v, l);
    chk("c_a3_lat", 32'(l), 32'd4);
    chk("c_a3_im", 32'(v), 32'hAA);
    write_seed(8'h01);
    do_req(4'd5, 2'd1, 0, 1'b0, 1'b0, v, l);
    chk("c_seed_a5_lat", 32'(l), 32'd6);

    // Seed write coinciding with a request is dropped.
    write_seed(8'h01);
    do_req(4'd1, 2'd1, 0, 1'b0, 1'b1, v, l);
    chk("coinc_im", 32'(v), 32'h82);
    do_req(4'd0, 2'd1, 0, 1'b0, 1'b0, v, l);
    chk("coinc_seed_kept", 32'(v), 32'h01);

    // Reset in the middle of a long computation.
    im_addr_i       = 4'd10;
    shift_amt_i     = 2'd1;
    im_addr_valid_i = 1'b1;
    tick();
    im_addr_valid_i = 1'b0;
    repeat (4) tick();
    chk("mid_busy", 32'(busy_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", 32'(im_valid_o), 32'd0);
    chk("arst_im",    32'(im_o), 32'd0);
    chk("arst_busy",  32'(busy_o), 32'd0);
    chk("arst_ready", 32'(im_addr_ready_o), 32'd0);
    repeat (2) tick();
    rst_ni = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (im_valid_o) seen++;
    end
    chk("no_valid_after_rst", 32'(seen), 32'd0);
    do_req(4'd1, 2'd1, 0, 1'b0, 1'b0, v, l);
    chk("post_rst_a1_im", 32'(v), 32'h00);
    chk("post_rst_a1_lat", 32'(l), 32'd2);

    // Randomized traffic; the per-cycle compare process checks everything.
    for (int k = 0; k < 80; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2) begin
        write_seed(8'($urandom));
      end else begin
        do_req(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), (r == 8), (r == 9), v, l);
      end
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ca90_im_gen.md
CA90_IM_GEN -- requirements
Module: ca90_im_gen

Interface
REQ-001 SHALL have parameter Dimension, default 512, hypervector width in bits.
REQ-002 SHALL have parameter MaxShiftAmt, default 128, upper bound on the CA90 rotate amount.
REQ-003 SHALL have parameter NumTotIm, default 1024, number of addressable item vectors; it SHALL be a power of two.
REQ-004 SHALL derive ShiftWidth = $clog2(MaxShiftAmt) and AddrWidth = $clog2(NumTotIm); neither is user-set.
REQ-005 Ports SHALL be as follows; the clock is a single clock, and the reset is asynchronous and active-low:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- seed_i  in  Dimension  seed vector
- seed_wr_i  in  1  load seed_i into the seed register
- shift_amt_i  in  ShiftWidth  CA90 rotate amount
- im_addr_i  in  AddrWidth  requested item index
- im_addr_valid_i  in  1  request valid
- im_addr_ready_o  out  1  request ready
- im_o  out  Dimension  generated item vector
- im_valid_o  out  1  result valid
- im_ready_i  in  1  result consumed
- busy_o  out  1  FSM not in IDLE

Function
REQ-006 SHALL compute im_o = CA90^a(seed), where a = accepted im_addr_i and CA90(v) = rotl(v,s) XOR rotr(v,s), with s the shift amount.
REQ-007 FSM SHALL have three states: IDLE, COMPUTE and DONE.
REQ-008 IDLE SHALL assert im_addr_ready_o=1.
- Handshake is im_addr_valid_i & im_addr_ready_o.
- On handshake, the FSM SHALL latch a and shift_amt_i.
- If the iteration count is 0, go to DONE with the work register equal to the start vector.
- Otherwise go to COMPUTE.
REQ-009 COMPUTE SHALL apply exactly one CA90 iteration per clock to the work register and decrement the remaining count; when the count reaches 0 it goes to DONE.
REQ-010 DONE SHALL assert im_valid_o=1 with im_o stable until im_ready_i=1, then return to IDLE; im_valid_o SHALL NOT depend combinationally on im_ready_i.
REQ-011 Latency SHALL be a+1 clocks from the request handshake edge to im_valid_o high (no cache hit).
REQ-012 im_addr_ready_o SHALL be 0 in COMPUTE and DONE; a new request SHALL be accepted no earlier than the cycle after the result handshake.
REQ-013 seed_wr_i SHALL load the seed only in IDLE and only when no request handshake occurs in the same cycle; otherwise it SHALL be ignored.
- If seed_wr_i and a request handshake coincide in IDLE, the request SHALL win and the seed write is dropped.
REQ-014 shift_amt_i changes after the request handshake SHALL NOT affect the in-flight computation.
REQ-015 shift 0 SHALL yield the all-zero vector after one or more iterations, consistent with out-of-range shifts evaluating to 0.
REQ-016 busy_o SHALL be 1 exactly when the state is not IDLE.

Reset
REQ-017 rst_ni low SHALL asynchronously force:
- state to IDLE
- seed, work and counter registers to 0
- im_valid_o=0, im_o=0, busy_o=0
- im_addr_ready_o to 1 once reset is released
REQ-018 Reset asserted mid-COMPUTE or in DONE SHALL discard the result; no im_valid_o pulse follows.

Configuration
REQ-019 Macro CA90_IM_CACHE_EN:
- Defined: the block SHALL retain the last delivered index L and vector with a cache-valid flag.
- On a hit (valid, a >= L, same shift amount), the block SHALL start from the cached vector and iterate a-L times.
- Latency on a hit SHALL be (a-L)+1.
- A seed write or reset SHALL clear the cache-valid flag.
- Undefined: the block SHALL always start from the seed, and no cache storage SHALL be synthesised.

Structure
REQ-020 FSM state enum and shared typedefs SHALL live in package ca90_im_pkg.
REQ-021 The CA90 step SHALL be one instance of the existing sub-module ca90_unit, fed from the work register; no other sub-modules.

Verification (Dimension=8, MaxShiftAmt=4, NumTotIm=16)
REQ-022 Seed write 8'h01 with shift 1 and request a=1 -> im_o=8'h82; im_valid_o rises 2 clocks after the handshake.
REQ-023 Same seed, a=2 -> im_o=8'h44 after 3 clocks; a=0 -> im_o=8'h01 after 1 clock.
REQ-024 im_ready_i held 0 for 5 cycles in DONE:
- im_o and im_valid_o SHALL stay stable;
- im_addr_ready_o SHALL stay 0;
- seed_wr_i pulsed in this window SHALL be ignored.
REQ-025 rst_ni pulsed low during COMPUTE of a=10:
- all outputs SHALL be 0 immediately;
- no im_valid_o SHALL follow;
- a subsequent a=1 request SHALL return 8'h00, since the seed was reset to 0.
REQ-026 With CA90_IM_CACHE_EN: a=2 then a=5 -> second latency is 4 clocks.
- a=3 after that -> full 4-clock recompute from the seed, im_o=CA90^3(8'h01).
- A seed write followed by a=5 -> 6-clock latency.
